// File: rtl/mul16_seq.sv
// Sequential unsigned shift-add multiplier. It performs one WIDTH-bit add with carry-out per cycle.
// A full 2*WIDTH-bit product is ready WIDTH cycles after start is accepted.
module mul16_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shifted;
    logic               last;
    logic               accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // busy and done decode from state only, so they cannot glitch when start toggles.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The adder carry becomes the MSB of acc_hi after the right shift.
    // Multiplier bits retire out of the bottom of acc_lo.
    always_comb begin
        addend  = acc_lo[0] ? mcand : '0;
        sum     = {1'b0, acc_hi} + {1'b0, addend};
        shifted = {sum, acc_lo[WIDTH-1:1]};
        last    = (count == LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            mcand  <= A;
            acc_hi <= '0;
            acc_lo <= B;
            count  <= '0;
        end else if (state == RUN) begin
            {acc_hi, acc_lo} <= shifted;
            count            <= count + CW'(1);
            if (last) begin
                product <= shifted;
            end
        end
    end

endmodule
